// File: rtl/cpu_mem_responder.sv
// Memory responder for the multi-cycle CPU: one shared 256 x 32 array serving
// fetch/load/store in RUN, plus a streaming loader that holds the CPU off while it fills the array.
module cpu_mem_responder #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic                 cpu_write,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic                 cpu_hold,
    input  logic                 ld_start,
    input  logic                 ld_valid,
    input  logic [WORD_SIZE-1:0] ld_data,
    input  logic                 ld_last,
    output logic                 ld_ready,
    output logic                 ld_done,
    output logic [15:0]          wr_count,
    output logic [1:0]           o_dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [ADDR_W:0]      r_ptr;
    logic [WORD_SIZE-1:0] r_mem [DEPTH];
    logic [WORD_SIZE-1:0] r_rdata;
    logic [15:0]          r_wr_count;

    logic                 w_ld_accept;
    logic                 w_ld_final;
    logic                 w_cpu_store;
    logic                 w_mem_we;
    logic [ADDR_W-1:0]    w_mem_waddr;
    logic [WORD_SIZE-1:0] w_mem_wdata;

    // Loader handshake: a word transfers on a rising edge where ld_valid and
    // ld_ready are both high; ld_ready is high only in LOAD. An ld_start in the
    // same cycle wins: the pointer rewinds to 0 and the presented word is dropped.
    always_comb begin
        w_ld_accept = (r_state == ST_LOAD) && ld_valid && !ld_start;
        w_ld_final  = w_ld_accept && (ld_last || (r_ptr == LAST_PTR));
        w_cpu_store = (r_state == ST_RUN) && cpu_write;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN: begin
                if (ld_start) begin
                    w_next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ld_start) begin
                    w_next_state = ST_LOAD;
                end else if (w_ld_final) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_RUN;
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    always_comb begin
        cpu_hold    = (r_state != ST_RUN);
        ld_ready    = (r_state == ST_LOAD);
        ld_done     = (r_state == ST_DONE);
        o_dbg_state = r_state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (ld_start && (r_state != ST_DONE)) begin
            r_ptr <= '0;
        end else if (w_ld_accept) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    // Single write port shared by the CPU (RUN) and the loader (LOAD); contents survive reset.
    always_comb begin
        w_mem_we    = rst_n && (w_cpu_store || w_ld_accept);
        w_mem_waddr = w_ld_accept ? r_ptr[ADDR_W-1:0] : cpu_addr;
        w_mem_wdata = w_ld_accept ? ld_data : cpu_wdata;
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    // Write-first read: a same-cycle store is forwarded straight to the read register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (r_state == ST_RUN) begin
            r_rdata <= cpu_write ? cpu_wdata : r_mem[cpu_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_count <= '0;
        end else if (w_cpu_store && (r_wr_count != 16'hFFFF)) begin
            r_wr_count <= r_wr_count + 16'd1;
        end
    end

    assign cpu_rdata = r_rdata;
    assign wr_count  = r_wr_count;

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the multi-cycle CPU's single instruction/data memory port (8-bit word address, write strobe, 32-bit write/read data).
- Serves CPU instruction fetches, loads and stores from a 256 x 32 word array.
- A streaming program-load port with a valid/ready handshake fills the array and holds the CPU off while loading.
- Sits between the CPU core and the board-level loader.

Parameters:
- WORD_SIZE, 32, data word width in bits.
- ADDR_W, 8, word address width.
- DEPTH, 256, number of words (2**ADDR_W).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- cpu_addr  in  ADDR_W  CPU word address (fetch, LW, SW).
- cpu_write  in  1  CPU store strobe; 1 = write cpu_wdata to cpu_addr this cycle.
- cpu_wdata  in  WORD_SIZE  CPU store data.
- cpu_rdata  out  WORD_SIZE  read data to CPU, registered.
- cpu_hold  out  1  1 = memory is busy loading; the CPU must not advance.
- ld_start  in  1  single-cycle pulse; begin/restart program load at word 0.
- ld_valid  in  1  loader word valid.
- ld_data  in  WORD_SIZE  loader word.
- ld_last  in  1  qualifies the final loader word; meaningful only with ld_valid.
- ld_ready  out  1  responder accepts a loader word this cycle.
- ld_done  out  1  single-cycle pulse when a load completes.
- wr_count  out  16  number of CPU stores accepted, saturating.

Behaviour:
Reset (rst_n=0 at a clock edge):
- State goes to RUN; load pointer = 0.
- cpu_rdata = 0, cpu_hold = 0, ld_ready = 0, ld_done = 0, wr_count = 0.
- Array contents are NOT cleared; words already written are retained.

States:
- RUN -> LOAD on ld_start=1.
- LOAD -> DONE on an accepted word (ld_valid & ld_ready) that has ld_last=1, or that is the word at pointer DEPTH-1.
- LOAD -> LOAD on ld_start=1: pointer resets to 0; a word presented in that same cycle is NOT written.
- DONE -> RUN unconditionally after one cycle.

RUN:
- Read latency is 1 cycle: cpu_rdata in cycle N+1 = mem[cpu_addr sampled in cycle N].
- A read is performed every cycle, with no read enable.
- Store: if cpu_write=1 at the edge, then mem[cpu_addr] <= cpu_wdata.
- Read and write to the same address in the same cycle is write-first: cpu_rdata returns the new cpu_wdata.
- Each accepted store increments wr_count, which sticks at 16'hFFFF.
- ld_valid is ignored; ld_ready = 0.

LOAD:
- cpu_hold = 1 and ld_ready = 1 (both registered, asserted the cycle after ld_start).
- On ld_valid & ld_ready: mem[pointer] <= ld_data, pointer++.
- The pointer is ADDR_W+1 bits wide, so no wrap occurs before the DEPTH-1 termination.
- cpu_write is ignored: no array write, wr_count unchanged.
- cpu_rdata holds its last value.
- ld_valid=0 stalls indefinitely, with no timeout.

DONE:
- ld_done = 1 for exactly one cycle; ld_ready = 0; cpu_hold = 1.
- Next cycle: cpu_hold = 0 and normal CPU reads resume.

Other rules:
- ld_start arriving in DONE is ignored.
- Reset in mid-load returns to RUN immediately; a partial image stays in the array.
- Address arithmetic is unsigned; cpu_addr covers the full DEPTH, with no out-of-range case.

Test Plan:
1. Reset, then in RUN store 32'h0000_0005 to addr 8'h10; next cycle read 8'h10 -> cpu_rdata = 32'h0000_0005 one cycle after the address is presented; wr_count = 1.
2. Same-cycle write 32'hDEAD_BEEF and read of addr 8'h20 -> cpu_rdata = 32'hDEAD_BEEF on the following cycle (write-first).
3. Pulse ld_start, stream 4 words 32'h1..32'h4 with gaps in ld_valid, ld_last on word 4.
   - cpu_hold = 1 throughout.
   - ld_done pulses once, one cycle after word 4 is accepted.
   - cpu_hold drops the following cycle.
   - Reads of addrs 0-3 return 1-4.
4. During LOAD, drive cpu_write=1 to addr 8'h50 with 32'hFFFF_FFFF -> after the load, mem[8'h50] is unchanged and wr_count is unchanged.
5. Stream 256 words with no ld_last -> DONE after word 255, and ld_ready = 0 thereafter; also pulse ld_start after 3 words -> the next word lands at addr 0.
6. Assert rst_n=0 after 2 of 5 load words -> next cycle cpu_hold = 0, ld_ready = 0; addrs 0-1 hold the loaded data; 1-cycle-latency reads work immediately.
